// File: rtl/fb_pkg.sv
// Shared constants, op codes and FSM encoding for the framebuffer fill engine.
package fb_pkg;

  localparam int FB_W = 160;  // framebuffer width in pixels
  localparam int FB_H = 120;  // framebuffer height in pixels
  localparam int XW   = 8;    // bits needed for an X coordinate
  localparam int YW   = 7;    // bits needed for a Y coordinate
  localparam int CW   = 9;    // RGB 3:3:3 colour width
  localparam int AW   = 10;   // external coordinate / address width

  typedef enum logic [1:0] {
    OP_FILL  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_PLOT  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_DRAW  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/fb_clip.sv
// Clamp both ends of one axis to [0, max] and order them so that a <= b.
module fb_clip #(
  parameter int IW = 10,
  parameter int OW = 8
) (
  input  logic [IW-1:0] lo_i,
  input  logic [IW-1:0] hi_i,
  input  logic [OW-1:0] max_i,
  output logic [OW-1:0] a_o,
  output logic [OW-1:0] b_o
);

  logic [IW-1:0] max_ext;
  logic [OW-1:0] lo_c;
  logic [OW-1:0] hi_c;

  assign max_ext = {{(IW-OW){1'b0}}, max_i};

  // Clamp each coordinate, then swap if the corners arrive reversed.
  always_comb begin
    lo_c = (lo_i > max_ext) ? max_i : lo_i[OW-1:0];
    hi_c = (hi_i > max_ext) ? max_i : hi_i[OW-1:0];
    if (lo_c <= hi_c) begin
      a_o = lo_c;
      b_o = hi_c;
    end else begin
      a_o = hi_c;
      b_o = lo_c;
    end
  end

endmodule

// File: rtl/fb_fill_engine.sv
// Command-driven rectangle fill / clear / plot engine feeding the framebuffer
// write port at one pixel per clock.
module fb_fill_engine #(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [9:0] cmd_x0,
  input  logic [9:0] cmd_x1,
  input  logic [9:0] cmd_y0,
  input  logic [9:0] cmd_y1,
  input  logic [8:0] cmd_color,
  input  logic       abort,
  output logic [9:0] WAx,
  output logic [9:0] WAy,
  output logic [8:0] dt,
  output logic       SW,
  output logic       busy,
  output logic       done,
  output logic       err
);

  import fb_pkg::*;

  localparam logic [XW-1:0] X_MAX = XW'(FB_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(FB_H - 1);

  state_e          state_q, state_d;
  op_e             op_q;
  logic [CW-1:0]   color_q;
  logic [AW-1:0]   x0_q, x1_q, y0_q, y1_q;
  logic [XW-1:0]   xa_q, xb_q, cx_q;
  logic [YW-1:0]   ya_q, yb_q, cy_q;

  // Registered outputs and their next values
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            sw_q, sw_d;
  logic [AW-1:0]   wax_q, wax_d;
  logic [AW-1:0]   way_q, way_d;
  logic [CW-1:0]   dt_q, dt_d;

  logic            accept, accept_rsvd, accept_cmd, last_px;
  logic [AW-1:0]   x_hi, y_hi;
  logic [XW-1:0]   clip_xa, clip_xb, bx_a, bx_b;
  logic [YW-1:0]   clip_ya, clip_yb, by_a, by_b;

  assign accept      = (state_q == ST_IDLE) && ready_q && cmd_valid;
  assign accept_rsvd = accept && (cmd_op == OP_RSVD);
  assign accept_cmd  = accept && (cmd_op != OP_RSVD);
  assign last_px     = (cx_q == xb_q) && (cy_q == yb_q);

  // A plot collapses each axis onto its first corner.
  assign x_hi = (op_q == OP_PLOT) ? x0_q : x1_q;
  assign y_hi = (op_q == OP_PLOT) ? y0_q : y1_q;

  fb_clip #(.IW(AW), .OW(XW)) u_clip_x (
    .lo_i (x0_q),
    .hi_i (x_hi),
    .max_i(X_MAX),
    .a_o  (clip_xa),
    .b_o  (clip_xb)
  );

  fb_clip #(.IW(AW), .OW(YW)) u_clip_y (
    .lo_i (y0_q),
    .hi_i (y_hi),
    .max_i(Y_MAX),
    .a_o  (clip_ya),
    .b_o  (clip_yb)
  );

  // Clear ignores the supplied corners and covers the whole screen.
  always_comb begin
    if (op_q == OP_CLEAR) begin
      bx_a = '0;
      bx_b = X_MAX;
      by_a = '0;
      by_b = Y_MAX;
    end else begin
      bx_a = clip_xa;
      bx_b = clip_xb;
      by_a = clip_ya;
      by_b = clip_yb;
    end
  end

  // FSM state register.
  always_ff @(posedge clk50) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; abort only matters in SETUP and DRAW.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept_cmd) state_d = ST_SETUP;
      ST_SETUP: state_d = abort ? ST_DONE : ST_DRAW;
      ST_DRAW:  if (abort || last_px) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs.
  always_comb begin
    sw_d    = 1'b0;
    wax_d   = wax_q;
    way_d   = way_q;
    dt_d    = dt_q;
    done_d  = (state_q == ST_DONE);
    err_d   = accept_rsvd;
    ready_d = (state_q == ST_IDLE) && !accept_cmd;
    busy_d  = !ready_d;
    if (state_q == ST_DRAW) begin
      sw_d  = !abort;
      wax_d = {{(AW-XW){1'b0}}, cx_q};
      way_d = {{(AW-YW){1'b0}}, cy_q};
      dt_d  = color_q;
    end
  end

  // Output registers; reset wins over everything so no done follows it.
  always_ff @(posedge clk50) begin
    if (rst) begin
      sw_q    <= 1'b0;
      wax_q   <= '0;
      way_q   <= '0;
      dt_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      sw_q    <= sw_d;
      wax_q   <= wax_d;
      way_q   <= way_d;
      dt_q    <= dt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Capture the command on acceptance so later input changes are ignored.
  always_ff @(posedge clk50) begin
    if (rst) begin
      op_q    <= OP_FILL;
      color_q <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
    end else if (accept_cmd) begin
      op_q    <= op_e'(cmd_op);
      color_q <= cmd_color;
      x0_q    <= cmd_x0;
      x1_q    <= cmd_x1;
      y0_q    <= cmd_y0;
      y1_q    <= cmd_y1;
    end
  end

  // Bounds load in SETUP, then raster scan with X inner and Y outer.
  always_ff @(posedge clk50) begin
    if (rst) begin
      xa_q <= '0;
      xb_q <= '0;
      ya_q <= '0;
      yb_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else if (state_q == ST_SETUP) begin
      xa_q <= bx_a;
      xb_q <= bx_b;
      ya_q <= by_a;
      yb_q <= by_b;
      cx_q <= bx_a;
      cy_q <= by_a;
    end else if (state_q == ST_DRAW) begin
      if (cx_q == xb_q) begin
        cx_q <= xa_q;
        cy_q <= cy_q + 1'b1;
      end else begin
        cx_q <= cx_q + 1'b1;
      end
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign SW        = sw_q;
  assign WAx       = wax_q;
  assign WAy       = way_q;
  assign dt        = dt_q;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Self-checking bench for fb_fill_engine: table of commands with expected
// bounds, a write scoreboard, and hand sequences for abort and reset.
module tb_fb_fill_engine;

  typedef struct {
    logic [1:0] op;
    int x0, x1, y0, y1;
    int color;
    int xa, xb, ya, yb;
  } vec_t;

  typedef struct {
    int x;
    int y;
    int c;
  } wr_t;

  logic       clk50;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [9:0] cmd_x0, cmd_x1, cmd_y0, cmd_y1;
  logic [8:0] cmd_color;
  logic       abort;
  logic [9:0] WAx, WAy;
  logic [8:0] dt;
  logic       SW, busy, done, err;

  fb_fill_engine dut (
    .clk50    (clk50),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_x0   (cmd_x0),
    .cmd_x1   (cmd_x1),
    .cmd_y0   (cmd_y0),
    .cmd_y1   (cmd_y1),
    .cmd_color(cmd_color),
    .abort    (abort),
    .WAx      (WAx),
    .WAy      (WAy),
    .dt       (dt),
    .SW       (SW),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  wr_cnt, busy_cnt, done_cnt;
  int  first_cyc, last_cyc, done_cyc;
  wr_t exp_q[$];
  vec_t vecs[8];

  always @(posedge clk50) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Write monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk50) begin
    wr_t e;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (SW) begin
      wr_cnt++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got (%0d,%0d,0x%0h) expected no write", WAx, WAy, dt);
      end else begin
        e = exp_q.pop_front();
        if (WAx !== 10'(e.x) || WAy !== 10'(e.y) || dt !== 9'(e.c)) begin
          n_fail++;
          $display("FAIL write_data: got (%0d,%0d,0x%0h) expected (%0d,%0d,0x%0h)",
                   WAx, WAy, dt, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic clear_stats();
    wr_cnt    = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    first_cyc = -1;
    last_cyc  = -1;
    done_cyc  = -1;
  endtask

  // Drive one command at a negedge, return the acceptance edge number.
  task automatic issue(input vec_t v, output int acc);
    @(negedge clk50);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_x0    = 10'(v.x0);
    cmd_x1    = 10'(v.x1);
    cmd_y0    = 10'(v.y0);
    cmd_y1    = 10'(v.y1);
    cmd_color = 9'(v.color);
    check("ready_before_cmd", cmd_ready, 1);
    @(posedge clk50);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_x0    = 10'($urandom);
    cmd_x1    = 10'($urandom);
    cmd_y0    = 10'($urandom);
    cmd_y1    = 10'($urandom);
    cmd_color = 9'($urandom);
  endtask

  // Run one command; abort_k > 0 aborts on that DRAW cycle.
  task automatic run_vec(input vec_t v, input int abort_k);
    int acc, p, n_exp, t, k;
    clear_stats();
    p = (v.xb - v.xa + 1) * (v.yb - v.ya + 1);
    n_exp = (abort_k > 0) ? abort_k - 1 : p;
    if (v.op == 2'b11) n_exp = 0;
    k = 0;
    for (int y = v.ya; y <= v.yb; y++)
      for (int x = v.xa; x <= v.xb; x++) begin
        if (k < n_exp) exp_q.push_back('{x, y, v.color});
        k++;
      end
    issue(v, acc);
    if (v.op == 2'b11) begin
      @(negedge clk50); #1;
      check("err_pulse", err, 1);
      check("err_ready", cmd_ready, 1);
      check("err_busy", busy, 0);
      @(negedge clk50); #1;
      check("err_one_cycle", err, 0);
      repeat (3) @(negedge clk50);
      #1;
      check("err_no_writes", wr_cnt, 0);
      check("err_no_done", done_cnt, 0);
      $display("[TB] cmd op=%0d reserved: err seen, writes=%0d", v.op, wr_cnt);
      return;
    end
    if (abort_k > 0) begin
      do begin @(negedge clk50); #1; end while (cyc < acc + abort_k);
      abort = 1'b1;
      @(negedge clk50);
      abort = 1'b0;
    end
    t = 0;
    while (done_cyc < 0 && t < p + 10) begin
      @(negedge clk50); #1;
      t++;
    end
    @(negedge clk50); #1;
    check("ready_after_done", cmd_ready, 1);
    check("busy_after_done", busy, 0);
    check("write_count", wr_cnt, n_exp);
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_pulses", done_cnt, 1);
    if (abort_k > 0) begin
      check("abort_done_cycle", done_cyc - acc, abort_k + 2);
    end else begin
      check("first_sw_latency", first_cyc - acc, 2);
      check("last_sw_cycle", last_cyc - acc, p + 1);
      check("done_cycle", done_cyc - acc, p + 2);
      check("busy_cycles", busy_cnt, p + 3);
    end
    exp_q.delete();
    $display("[TB] cmd op=%0d (%0d,%0d)-(%0d,%0d) writes=%0d done_at=+%0d",
             v.op, v.xa, v.ya, v.xb, v.yb, wr_cnt, done_cyc - acc);
  endtask

  initial begin
    int acc;
    vec_t abv, clr;
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; cmd_op = 2'b00;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
    clear_stats();

    //           op    x0    x1   y0    y1   color   xa   xb   ya   yb
    vecs[0] = '{2'b00,    2,   4,    3,   4, 'h1C0,   2,   4,   3,   4};
    vecs[1] = '{2'b00,  200, 150,    5,   5, 'h0AA, 150, 159,   5,   5};
    vecs[2] = '{2'b10,   10,   0,   20,   0, 'h155,  10,  10,  20,  20};
    vecs[3] = '{2'b00,    7,   3,    9,   6, 'h03F,   3,   7,   6,   9};
    vecs[4] = '{2'b00,    0,   1,  500, 118, 'h1FF,   0,   1, 118, 119};
    vecs[5] = '{2'b10, 1023,   5, 1023,   5, 'h123, 159, 159, 119, 119};
    vecs[6] = '{2'b01,   33,  44,   55,  66, 'h000,   0, 159,   0, 119};
    vecs[7] = '{2'b11,    1,   2,    3,   4, 'h0F0,   0,   0,   0,   0};

    repeat (3) @(posedge clk50);
    @(negedge clk50); #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_SW", SW, 0);
    check("rst_WAx", WAx, 0);
    check("rst_WAy", WAy, 0);
    check("rst_dt", dt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 0);

    // Abort on the 4th DRAW cycle of a 10-pixel fill, then a normal command.
    abv = '{2'b00, 0, 9, 0, 0, 'h0C3, 0, 9, 0, 0};
    run_vec(abv, 4);
    run_vec(vecs[0], 0);

    // Reset in the middle of a clear.
    clr = vecs[6];
    clr.color = 'h1A5;
    clear_stats();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) exp_q.push_back('{x, y, clr.color});
    issue(clr, acc);
    do begin @(negedge clk50); #1; end while (cyc < acc + 50);
    rst = 1'b1;
    @(negedge clk50); #1;
    check("midrst_SW", SW, 0);
    check("midrst_WAx", WAx, 0);
    check("midrst_WAy", WAy, 0);
    check("midrst_dt", dt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_writes", wr_cnt, 49);
    exp_q.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk50);
    #1;
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_more_writes", wr_cnt, 49);
    $display("[TB] reset mid-clear after %0d writes, done pulses=%0d", wr_cnt, done_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
